// File: rtl/pipe_ctrl_gen.sv
// Pipelined MIPS control unit: D-stage decode and PC select, E/M/W control
// registers with E flush, and a mult/div sequencer that freezes the front end.
module pipe_ctrl_gen #(
    parameter int ALUCW = 3,
    parameter int MDLAT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op_d,
    input  logic [5:0]       funct_d,
    input  logic             equal_d,
    input  logic             flush_e,
    output logic [1:0]       pcsrc_d,
    output logic             branch_d,
    output logic             illegal_d,
    output logic             regwrite_e,
    output logic             memtoreg_e,
    output logic             regdst_e,
    output logic             alusrc_e,
    output logic [ALUCW-1:0] alucontrol_e,
    output logic [1:0]       mdop_e,
    output logic             md_start,
    output logic             md_stall,
    output logic             regwrite_m,
    output logic             memtoreg_m,
    output logic             memwrite_m,
    output logic             regwrite_w,
    output logic             memtoreg_w
);

    typedef struct packed {
        logic             regwrite;
        logic             memtoreg;
        logic             memwrite;
        logic             regdst;
        logic             alusrc;
        logic [ALUCW-1:0] alu;
        logic [1:0]       mdop;
    } ctrl_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

    ctrl_t     ctrl_d;
    ctrl_t     e_q, e_d;
    logic [2:0] m_q, m_d;       // {regwrite, memtoreg, memwrite}
    logic [1:0] w_q, w_d;       // {regwrite, memtoreg}
    logic [2:0] alu3;
    logic       is_beq, is_bne, is_j;
    md_state_t  state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    // Instruction decode: one bundle per op/funct, everything else illegal
    always_comb begin
        ctrl_d    = '0;
        alu3      = 3'b000;
        is_beq    = 1'b0;
        is_bne    = 1'b0;
        is_j      = 1'b0;
        illegal_d = 1'b0;
        case (op_d)
            6'b000000: begin
                case (funct_d)
                    6'b100000: begin ctrl_d.regwrite = 1'b1; ctrl_d.regdst = 1'b1; alu3 = 3'b010; end
                    6'b100010: begin ctrl_d.regwrite = 1'b1; ctrl_d.regdst = 1'b1; alu3 = 3'b110; end
                    6'b100100: begin ctrl_d.regwrite = 1'b1; ctrl_d.regdst = 1'b1; alu3 = 3'b000; end
                    6'b100101: begin ctrl_d.regwrite = 1'b1; ctrl_d.regdst = 1'b1; alu3 = 3'b001; end
                    6'b101010: begin ctrl_d.regwrite = 1'b1; ctrl_d.regdst = 1'b1; alu3 = 3'b111; end
                    6'b011000: ctrl_d.mdop = 2'b01;
                    6'b011010: ctrl_d.mdop = 2'b10;
                    default:   illegal_d = 1'b1;
                endcase
            end
            6'b100011: begin ctrl_d.regwrite = 1'b1; ctrl_d.memtoreg = 1'b1; ctrl_d.alusrc = 1'b1; alu3 = 3'b010; end
            6'b101011: begin ctrl_d.memwrite = 1'b1; ctrl_d.alusrc = 1'b1; alu3 = 3'b010; end
            6'b000100: begin is_beq = 1'b1; alu3 = 3'b110; end
            6'b000101: begin is_bne = 1'b1; alu3 = 3'b110; end
            6'b001000: begin ctrl_d.regwrite = 1'b1; ctrl_d.alusrc = 1'b1; alu3 = 3'b010; end
            6'b000010: is_j = 1'b1;
            default:   illegal_d = 1'b1;
        endcase
        ctrl_d.alu = ALUCW'(alu3);
    end

    // PC select resolved in D; jump wins, stall gating is left to the hazard unit
    always_comb begin
        branch_d = is_beq | is_bne;
        if (is_j)
            pcsrc_d = 2'b10;
        else if ((is_beq & equal_d) | (is_bne & ~equal_d))
            pcsrc_d = 2'b01;
        else
            pcsrc_d = 2'b00;
    end

    // Mult/div sequencer next state; stall covers the start cycle plus BUSY
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        md_start = 1'b0;
        md_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if ((e_q.mdop != 2'b00) && !flush_e) begin
                    md_start = 1'b1;
                    md_stall = 1'b1;
                    cnt_d    = 8'(MDLAT - 1);
                    state_d  = (MDLAT == 1) ? DONE : BUSY;
                end
            end
            BUSY: begin
                md_stall = 1'b1;
                cnt_d    = cnt_q - 8'd1;
                if (cnt_q == 8'd1)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_e) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
        end
    end

    // Pipeline register next state: E holds under stall, flush beats hold, M takes bubbles
    always_comb begin
        e_d = e_q;
        if (flush_e)
            e_d = '0;
        else if (!md_stall)
            e_d = ctrl_d;
        m_d = md_stall ? 3'b000 : {e_q.regwrite, e_q.memtoreg, e_q.memwrite};
        w_d = m_q[2:1];
    end

    // State and pipeline registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            e_q     <= '0;
            m_q     <= 3'b000;
            w_q     <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            m_q     <= m_d;
            w_q     <= w_d;
        end
    end

    assign regwrite_e   = e_q.regwrite;
    assign memtoreg_e   = e_q.memtoreg;
    assign regdst_e     = e_q.regdst;
    assign alusrc_e     = e_q.alusrc;
    assign alucontrol_e = e_q.alu;
    assign mdop_e       = e_q.mdop;
    assign regwrite_m   = m_q[2];
    assign memtoreg_m   = m_q[1];
    assign memwrite_m   = m_q[0];
    assign regwrite_w   = w_q[1];
    assign memtoreg_w   = w_q[0];

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Scoreboard bench for pipe_ctrl_gen: two instances (MDLAT=4/ALUCW=4 and
// MDLAT=1/ALUCW=3) share stimulus; a table-driven model predicts each cycle.
module tb_pipe_ctrl_gen;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] funct;
        logic       rw, mtr, mw, rd, as;
        logic [2:0] alu;
        logic [1:0] md;
        logic [1:0] kind;   // 0 plain, 1 beq, 2 bne, 3 j
    } ins_t;

    typedef struct packed {
        logic       rw, mtr, mw, rd, as;
        logic [3:0] alu;
        logic [1:0] md;
    } ectl_t;

    typedef struct packed {
        logic [1:0] pcsrc;
        logic       branch, illegal;
        logic       rw_e, mtr_e, rd_e, as_e;
        logic [3:0] alu_e;
        logic [1:0] md_e;
        logic       start, stall;
        logic       rw_m, mtr_m, mw_m;
        logic       rw_w, mtr_w;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op_d = 6'h3f;
    logic [5:0] funct_d = 6'h00;
    logic       equal_d = 1'b0;
    logic       flush_e = 1'b0;

    logic [1:0] pcsrc4, pcsrc1, mdop4, mdop1;
    logic       branch4, branch1, illegal4, illegal1;
    logic       rwe4, rwe1, mtre4, mtre1, rde4, rde1, ase4, ase1;
    logic [3:0] alu4;
    logic [2:0] alu1;
    logic       start4, start1, stall4, stall1;
    logic       rwm4, rwm1, mtrm4, mtrm1, mwm4, mwm1, rww4, rww1, mtrw4, mtrw1;

    obs_t act0, act1;
    obs_t q0[$];
    obs_t q1[$];
    ins_t tab[$];

    int n_chk = 0;
    int n_fail = 0;

    ectl_t      mE[2];
    logic [2:0] mM[2];
    logic [1:0] mW[2];
    int         busy[2];
    logic       donep[2];
    int         mdlat[2] = '{4, 1};

    always #5 clk = ~clk;

    pipe_ctrl_gen #(.ALUCW(4), .MDLAT(4)) u_dut4 (
        .clk(clk), .reset(reset), .op_d(op_d), .funct_d(funct_d), .equal_d(equal_d),
        .flush_e(flush_e), .pcsrc_d(pcsrc4), .branch_d(branch4), .illegal_d(illegal4),
        .regwrite_e(rwe4), .memtoreg_e(mtre4), .regdst_e(rde4), .alusrc_e(ase4),
        .alucontrol_e(alu4), .mdop_e(mdop4), .md_start(start4), .md_stall(stall4),
        .regwrite_m(rwm4), .memtoreg_m(mtrm4), .memwrite_m(mwm4),
        .regwrite_w(rww4), .memtoreg_w(mtrw4));

    pipe_ctrl_gen #(.ALUCW(3), .MDLAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .op_d(op_d), .funct_d(funct_d), .equal_d(equal_d),
        .flush_e(flush_e), .pcsrc_d(pcsrc1), .branch_d(branch1), .illegal_d(illegal1),
        .regwrite_e(rwe1), .memtoreg_e(mtre1), .regdst_e(rde1), .alusrc_e(ase1),
        .alucontrol_e(alu1), .mdop_e(mdop1), .md_start(start1), .md_stall(stall1),
        .regwrite_m(rwm1), .memtoreg_m(mtrm1), .memwrite_m(mwm1),
        .regwrite_w(rww1), .memtoreg_w(mtrw1));

    assign act0 = {pcsrc4, branch4, illegal4, rwe4, mtre4, rde4, ase4, alu4, mdop4,
                   start4, stall4, rwm4, mtrm4, mwm4, rww4, mtrw4};
    assign act1 = {pcsrc1, branch1, illegal1, rwe1, mtre1, rde1, ase1, {1'b0, alu1}, mdop1,
                   start1, stall1, rwm1, mtrm1, mwm1, rww1, mtrw1};

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d at %0t: got %0h, expected %0h", nm, k, $time, act, exp);
        end
    endtask

    task automatic cmp(input int k, input obs_t e, input obs_t a);
        chk("pcsrc_d", k, 32'(a.pcsrc), 32'(e.pcsrc));
        chk("branch_d", k, 32'(a.branch), 32'(e.branch));
        chk("illegal_d", k, 32'(a.illegal), 32'(e.illegal));
        chk("regwrite_e", k, 32'(a.rw_e), 32'(e.rw_e));
        chk("memtoreg_e", k, 32'(a.mtr_e), 32'(e.mtr_e));
        chk("regdst_e", k, 32'(a.rd_e), 32'(e.rd_e));
        chk("alusrc_e", k, 32'(a.as_e), 32'(e.as_e));
        chk("alucontrol_e", k, 32'(a.alu_e), 32'(e.alu_e));
        chk("mdop_e", k, 32'(a.md_e), 32'(e.md_e));
        chk("md_start", k, 32'(a.start), 32'(e.start));
        chk("md_stall", k, 32'(a.stall), 32'(e.stall));
        chk("regwrite_m", k, 32'(a.rw_m), 32'(e.rw_m));
        chk("memtoreg_m", k, 32'(a.mtr_m), 32'(e.mtr_m));
        chk("memwrite_m", k, 32'(a.mw_m), 32'(e.mw_m));
        chk("regwrite_w", k, 32'(a.rw_w), 32'(e.rw_w));
        chk("memtoreg_w", k, 32'(a.mtr_w), 32'(e.mtr_w));
    endtask

    // Monitor: compare whatever the driver predicted for the current cycle
    always @(negedge clk) begin
        if (q0.size() > 0) cmp(0, q0.pop_front(), act0);
        if (q1.size() > 0) cmp(1, q1.pop_front(), act1);
    end

    task automatic add_ins(input logic [5:0] op, input logic [5:0] fn, input logic rw, input logic mtr,
                           input logic mw, input logic rd, input logic as, input logic [2:0] alu,
                           input logic [1:0] md, input logic [1:0] kind);
        ins_t t;
        t = {op, fn, rw, mtr, mw, rd, as, alu, md, kind};
        tab.push_back(t);
    endtask

    // Look the instruction up in the table; a miss means illegal
    function automatic logic lookup(input logic [5:0] op, input logic [5:0] fn, output ins_t hit);
        hit = '0;
        foreach (tab[i])
            if (tab[i].op == op && (op != 6'h00 || tab[i].funct == fn)) begin
                hit = tab[i];
                return 1'b1;
            end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mE[k] = '0; mM[k] = '0; mW[k] = '0; busy[k] = 0; donep[k] = 1'b0;
        end
    endtask

    // Present one cycle of input, predict outputs, advance the model, then cross the edge
    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic eq, input logic fl);
        ins_t  d;
        logic  legal;
        obs_t  e;
        ectl_t cur;
        logic  stall, start;
        op_d = op; funct_d = fn; equal_d = eq; flush_e = fl;
        legal = lookup(op, fn, d);
        for (int k = 0; k < 2; k++) begin
            cur   = mE[k];
            start = (busy[k] == 0) && !donep[k] && (cur.md != 2'b00) && !fl;
            stall = (busy[k] > 0) || start;
            e.pcsrc   = (d.kind == 2'd3) ? 2'b10 :
                        (((d.kind == 2'd1) && eq) || ((d.kind == 2'd2) && !eq)) ? 2'b01 : 2'b00;
            e.branch  = (d.kind == 2'd1) || (d.kind == 2'd2);
            e.illegal = !legal;
            e.rw_e = cur.rw; e.mtr_e = cur.mtr; e.rd_e = cur.rd; e.as_e = cur.as;
            e.alu_e = cur.alu; e.md_e = cur.md;
            e.start = start; e.stall = stall;
            e.rw_m = mM[k][2]; e.mtr_m = mM[k][1]; e.mw_m = mM[k][0];
            e.rw_w = mW[k][1]; e.mtr_w = mW[k][0];
            if (k == 0) q0.push_back(e); else q1.push_back(e);
            if (fl) begin
                busy[k] = 0; donep[k] = 1'b0;
            end else if (start) begin
                busy[k] = mdlat[k] - 1; donep[k] = (busy[k] == 0);
            end else if (busy[k] > 0) begin
                busy[k]--; donep[k] = (busy[k] == 0);
            end else begin
                donep[k] = 1'b0;
            end
            mW[k] = mM[k][2:1];
            mM[k] = stall ? 3'b000 : {cur.rw, cur.mtr, cur.mw};
            if (fl) mE[k] = '0;
            else if (!stall) mE[k] = {d.rw, d.mtr, d.mw, d.rd, d.as, {1'b0, d.alu}, d.md};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_stall4"}, 0, 32'(stall4), 0);
        chk({tag, "_start4"}, 0, 32'(start4), 0);
        chk({tag, "_stall1"}, 1, 32'(stall1), 0);
        chk({tag, "_start1"}, 1, 32'(start1), 0);
        chk({tag, "_eflags4"}, 0, 32'({rwe4, mtre4, rde4, ase4, alu4, mdop4}), 0);
        chk({tag, "_mwflags4"}, 0, 32'({rwm4, mtrm4, mwm4, rww4, mtrw4}), 0);
        chk({tag, "_eflags1"}, 1, 32'({rwe1, mtre1, rde1, ase1, alu1, mdop1}), 0);
        chk({tag, "_mwflags1"}, 1, 32'({rwm1, mtrm1, mwm1, rww1, mtrw1}), 0);
    endtask

    localparam logic [5:0] BAD = 6'h3f;

    initial begin
        add_ins(6'h00, 6'h20, 1, 0, 0, 1, 0, 3'b010, 2'b00, 2'd0);
        add_ins(6'h00, 6'h22, 1, 0, 0, 1, 0, 3'b110, 2'b00, 2'd0);
        add_ins(6'h00, 6'h24, 1, 0, 0, 1, 0, 3'b000, 2'b00, 2'd0);
        add_ins(6'h00, 6'h25, 1, 0, 0, 1, 0, 3'b001, 2'b00, 2'd0);
        add_ins(6'h00, 6'h2a, 1, 0, 0, 1, 0, 3'b111, 2'b00, 2'd0);
        add_ins(6'h00, 6'h18, 0, 0, 0, 0, 0, 3'b000, 2'b01, 2'd0);
        add_ins(6'h00, 6'h1a, 0, 0, 0, 0, 0, 3'b000, 2'b10, 2'd0);
        add_ins(6'h23, 6'h00, 1, 1, 0, 0, 1, 3'b010, 2'b00, 2'd0);
        add_ins(6'h2b, 6'h00, 0, 0, 1, 0, 1, 3'b010, 2'b00, 2'd0);
        add_ins(6'h04, 6'h00, 0, 0, 0, 0, 0, 3'b110, 2'b00, 2'd1);
        add_ins(6'h05, 6'h00, 0, 0, 0, 0, 0, 3'b110, 2'b00, 2'd2);
        add_ins(6'h08, 6'h00, 1, 0, 0, 0, 1, 3'b010, 2'b00, 2'd0);
        add_ins(6'h02, 6'h00, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'd3);

        #1 reset = 1'b0;
        #1 check_reset_state("reset");
        model_reset();
        @(posedge clk); @(posedge clk);
        #1 reset = 1'b1;

        // add flows E -> M -> W, illegal filler behind it
        step(6'h00, 6'h20, 0, 0);
        repeat (3) step(BAD, 6'h00, 0, 0);
        // branch/jump PC select
        step(6'h05, 6'h00, 0, 0);
        step(6'h05, 6'h00, 1, 0);
        step(6'h02, 6'h00, 1, 0);
        step(6'h04, 6'h00, 1, 0);
        step(BAD, 6'h00, 0, 0);
        // lw squashed in E
        step(6'h23, 6'h00, 0, 0);
        step(BAD, 6'h00, 0, 1);
        repeat (3) step(BAD, 6'h00, 0, 0);
        // mult with adds queued behind
        step(6'h00, 6'h18, 0, 0);
        repeat (7) step(6'h00, 6'h20, 0, 0);
        // back-to-back divs
        repeat (3) step(6'h00, 6'h1a, 0, 0);
        repeat (12) step(6'h00, 6'h25, 0, 0);
        // reset while the MDLAT=4 unit is busy
        step(6'h00, 6'h18, 0, 0);
        step(6'h00, 6'h20, 0, 0);
        step(6'h00, 6'h20, 0, 0);
        chk("busy_before_reset", 0, 32'(stall4), 1);
        reset = 1'b0;
        #1 check_reset_state("midbusy");
        model_reset();
        @(posedge clk); @(posedge clk);
        #1 reset = 1'b1;
        repeat (4) step(6'h00, 6'h20, 0, 0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            int    r;
            logic [5:0] op, fn;
            r = $urandom_range(0, 15);
            if (r < 13) begin
                op = tab[r].op; fn = tab[r].funct;
            end else if (r == 13) begin
                op = 6'($urandom_range(0, 63)); fn = 6'($urandom_range(0, 63));
            end else begin
                op = 6'h00; fn = 6'($urandom_range(0, 63));
            end
            step(op, fn, 1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0));
        end

        @(negedge clk);
        chk("q0_drained", 0, 32'(q0.size()), 0);
        chk("q1_drained", 1, 32'(q1.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
